// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared line-interface constants and FSM state encoding
package mem_if_pkg;

  localparam int LINE_W         = 128;
  localparam int OFFSET_BITS    = 4;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port line array with write enable and registered read
module line_ram #(
  parameter int INDEX_W = 10,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               we,
  input  logic [INDEX_W-1:0] addr,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);

  logic [LINE_W-1:0] mem [2**INDEX_W];

  // Array kept free of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only moves on a read access, so it holds the last read line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - line-fill/write-back memory responder with programmable latency
module line_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = mem_if_pkg::LINE_W,
  parameter int INDEX_W = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] data_to_mem,
  output logic              mem_ready,
  output logic [LINE_W-1:0] data_from_mem,
  output logic              busy,
  output logic              protocol_err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  import mem_if_pkg::*;

  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

  mem_state_e         state;
  logic [7:0]         cnt;
  logic               lat_write;
  logic [INDEX_W-1:0] lat_index;
  logic [LINE_W-1:0]  lat_data;

  logic               req;
  logic [INDEX_W-1:0] req_index;
  logic               fire;
  logic               fire_write;
  logic [INDEX_W-1:0] ram_addr;
  logic [LINE_W-1:0]  ram_wdata;
  logic               unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign req_index        = mem_addr[INDEX_W+OFFSET_BITS-1:OFFSET_BITS];
  assign unused_addr_bits = ^{mem_addr[ADDR_W-1:INDEX_W+OFFSET_BITS], mem_addr[OFFSET_BITS-1:0]};

  // fire marks the edge that enters DONE; with LATENCY==1 that is the sampling edge itself,
  // so the array is addressed straight from the request inputs.
  always_comb begin
    fire       = 1'b0;
    fire_write = lat_write;
    ram_addr   = lat_index;
    ram_wdata  = lat_data;
    if (state == ST_IDLE) begin
      fire       = req && (LATENCY == 1);
      fire_write = mem_write;
      ram_addr   = req_index;
      ram_wdata  = data_to_mem;
    end else if (state == ST_BUSY) begin
      fire = (cnt == 8'd1);
    end
    if (!reset) begin
      fire = 1'b0;
    end
  end

  line_ram #(
    .INDEX_W(INDEX_W),
    .LINE_W (LINE_W)
  ) u_line_ram (
    .clk   (clk),
    .resetn(reset),
    .en    (fire),
    .we    (fire_write),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (data_from_mem)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_index    <= '0;
      lat_data     <= '0;
      mem_ready    <= 1'b0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      mem_ready <= 1'b0;
      if (fire) begin
        mem_ready <= 1'b1;
        busy      <= 1'b0;
        state     <= ST_DONE;
        if (fire_write) begin
          wr_count <= wr_count + 16'd1;
        end else begin
          rd_count <= rd_count + 16'd1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            // A read+write collision is served as a write.
            lat_write <= mem_write;
            lat_index <= req_index;
            lat_data  <= data_to_mem;
            cnt       <= LAT_INIT;
            if (mem_read && mem_write) begin
              protocol_err <= 1'b1;
            end
            if (LATENCY != 1) begin
              busy  <= 1'b1;
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt != 8'd1) begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - scoreboard bench for line_mem_responder at LATENCY 4 and 1
module tb_line_mem_responder;

  import mem_if_pkg::*;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         a_read, a_write, a_ready, a_busy, a_perr;
  logic [31:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic [15:0]  a_rdc, a_wrc;

  logic         b_read, b_write, b_ready, b_busy, b_perr;
  logic [31:0]  b_addr;
  logic [127:0] b_wdata, b_rdata;
  logic [15:0]  b_rdc, b_wrc;

  line_mem_responder #(.LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .mem_read(a_read), .mem_write(a_write), .mem_addr(a_addr),
    .data_to_mem(a_wdata), .mem_ready(a_ready), .data_from_mem(a_rdata), .busy(a_busy),
    .protocol_err(a_perr), .rd_count(a_rdc), .wr_count(a_wrc)
  );

  line_mem_responder #(.LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .mem_read(b_read), .mem_write(b_write), .mem_addr(b_addr),
    .data_to_mem(b_wdata), .mem_ready(b_ready), .data_from_mem(b_rdata), .busy(b_busy),
    .protocol_err(b_perr), .rd_count(b_rdc), .wr_count(b_wrc)
  );

  typedef struct {
    bit           chk_data;
    logic [127:0] data;
    int           rd;
    int           wr;
    bit           perr;
    int           due;
  } exp_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: line contents per (dut, index), plus expected counters and flags.
  logic [127:0] mdl [int];
  int           m_rd [2];
  int           m_wr [2];
  bit           m_perr [2];
  logic [127:0] m_last [2];
  bit           m_last_ok [2];
  exp_t         q0 [$];
  exp_t         q1 [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input string tag, input exp_t e, input logic [127:0] rdata,
                            input logic [15:0] rdc, input logic [15:0] wrc,
                            input logic perr, input logic bsy);
    chk({tag, "_latency"}, cyc, e.due);
    if (e.chk_data) chk({tag, "_data"}, rdata, e.data);
    chk({tag, "_rd_count"}, rdc, e.rd);
    chk({tag, "_wr_count"}, wrc, e.wr);
    chk({tag, "_protocol_err"}, perr, e.perr);
    chk({tag, "_busy"}, bsy, 1'b0);
  endtask

  exp_t e0, e1;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  always @(negedge clk) begin
    if (a_ready) begin
      chk("a_ready_width", prev0, 1'b0);
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_ready: got pulse at cycle %0d expected none", cyc);
      end else begin
        e0 = q0.pop_front();
        check_resp("a", e0, a_rdata, a_rdc, a_wrc, a_perr, a_busy);
      end
    end
    prev0 = a_ready;
  end

  always @(negedge clk) begin
    if (b_ready) begin
      chk("b_ready_width", prev1, 1'b0);
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_ready: got pulse at cycle %0d expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        check_resp("b", e1, b_rdata, b_rdc, b_wrc, b_perr, b_busy);
      end
    end
    prev1 = b_ready;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [127:0] data);
    if (sel == 0) begin
      a_read = rd; a_write = wr; a_addr = addr; a_wdata = data;
    end else begin
      b_read = rd; b_write = wr; b_addr = addr; b_wdata = data;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_rd[s] = 0; m_wr[s] = 0; m_perr[s] = 1'b0;
      m_last[s] = '0; m_last_ok[s] = 1'b1;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following mem_ready, request dropped.
  task automatic issue(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [127:0] data);
    exp_t e;
    int   key;
    int   n;
    bit   seen;
    key = sel * 4096 + int'(addr[13:4]);
    if (wr) begin
      mdl[key] = data;
      m_wr[sel]++;
      if (rd) m_perr[sel] = 1'b1;
      e.chk_data = m_last_ok[sel];
      e.data     = m_last[sel];
    end else begin
      m_rd[sel]++;
      if (mdl.exists(key)) begin
        e.chk_data = 1'b1;
        e.data     = mdl[key];
        m_last[sel] = mdl[key];
        m_last_ok[sel] = 1'b1;
      end else begin
        e.chk_data = 1'b0;
        e.data     = '0;
        m_last_ok[sel] = 1'b0;
      end
    end
    e.rd   = m_rd[sel];
    e.wr   = m_wr[sel];
    e.perr = m_perr[sel];
    e.due  = cyc + ((sel == 0) ? LAT_A : LAT_B);
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    drive(sel, rd, wr, addr, data);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = (sel == 0) ? a_ready : b_ready;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: dut %0d addr %h got no mem_ready within 300 cycles", sel, addr);
      if (sel == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
    sync();
    drive(sel, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [127:0] rand_line();
    logic [127:0] d;
    for (int w = 0; w < WORDS_PER_LINE; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d_old, d_new, d_rand;
    logic [31:0]  addr;
    int           pulses, sel, op;

    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", a_ready, 1'b0);
    chk("reset_busy", a_busy, 1'b0);
    chk("reset_rd_count", a_rdc, 16'd0);
    chk("reset_wr_count", a_wrc, 16'd0);
    chk("reset_protocol_err", a_perr, 1'b0);
    chk("reset_data", a_rdata, 128'd0);
    sync();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ready) pulses++;
    end
    chk("post_reset_no_pulse", pulses, 0);
    sync();

    issue(0, 1'b0, 1'b1, 32'h0000_0010, 128'hA000_000B_A000_001B_A000_002B_A000_003B);
    issue(0, 1'b1, 1'b0, 32'h0000_0010, '0);

    // Back-to-back: the second request is asserted in the first IDLE cycle.
    issue(0, 1'b0, 1'b1, 32'h0000_0020, rand_line());
    issue(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    issue(0, 1'b1, 1'b0, 32'h0000_0020, '0);

    issue(0, 1'b1, 1'b1, 32'h0000_0030, rand_line());
    issue(0, 1'b1, 1'b0, 32'h0000_0030, '0);

    d_old = rand_line();
    issue(0, 1'b0, 1'b1, 32'h0000_0050, d_old);

    // Reset in the second BUSY cycle of a write that must be dropped.
    d_new = rand_line();
    drive(0, 1'b0, 1'b1, 32'h0000_0050, d_new);
    sync();
    sync();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    model_reset();
    sync();
    sync();
    reset = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_ready) pulses++;
    end
    chk("midop_no_ready", pulses, 0);
    chk("midop_busy", a_busy, 1'b0);
    chk("midop_wr_count", a_wrc, 16'd0);
    chk("midop_protocol_err", a_perr, 1'b0);
    sync();
    issue(0, 1'b1, 1'b0, 32'h0000_0050, '0);

    issue(1, 1'b0, 1'b1, 32'h0000_4010, rand_line());
    issue(1, 1'b1, 1'b0, 32'h0000_0010, '0);

    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 1);
      addr = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 4) | ($urandom & 32'hF);
      op   = $urandom_range(0, 9);
      d_rand = rand_line();
      if (op == 0)      issue(sel, 1'b1, 1'b1, addr, d_rand);
      else if (op < 5)  issue(sel, 1'b1, 1'b0, addr, '0);
      else              issue(sel, 1'b0, 1'b1, addr, d_rand);
      repeat ($urandom_range(0, 2)) sync();
    end

    repeat (10) sync();
    chk("queue_drain", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
